// File: rtl/imem_prefetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, addresses the instruction ROM
// and buffers returned words in a small prefetch FIFO for the decode stage.
module imem_prefetch_ctrl #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 10001
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     EN,
  output logic [31:0]              IMEM_A,
  input  logic [31:0]              IMEM_RD,
  input  logic                     REDIRECT,
  input  logic [31:0]              REDIRECT_PC,
  output logic                     INSTR_VALID,
  input  logic                     INSTR_READY,
  output logic [31:0]              INSTR,
  output logic [31:0]              INSTR_PC,
  output logic                     INSTR_FAULT,
  output logic [$clog2(DEPTH):0]   COUNT
);

  localparam int unsigned PW      = $clog2(DEPTH);
  localparam int unsigned CW      = PW + 1;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic [31:0]     instr_mem_q [DEPTH];
  logic [31:0]     pc_mem_q    [DEPTH];
  logic            fault_mem_q [DEPTH];

  logic            head_valid;
  logic            pop;
  logic            push;
  logic            fault;
  logic [31:0]     wr_instr;

  // Handshake, push qualification and out-of-range detection
  always_comb begin
    head_valid = (count_q != '0);
    pop        = head_valid & INSTR_READY;
    fault      = ({2'b00, fetch_pc_q[31:2]} >= MEM_WORDS);
    wr_instr   = fault ? NOP : IMEM_RD;
    push       = (state_q == RUN) & EN & ~REDIRECT &
                 ((count_q < CW'(DEPTH)) | pop);
  end

  // Next-state for FSM, fetch PC, pointers and occupancy
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (REDIRECT) begin
      // Flush wins over any pop or push in the same cycle
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      fetch_pc_d = {REDIRECT_PC[31:2], 2'b00};
      state_d    = EN ? RUN : IDLE;
    end else begin
      if (push) begin
        wr_ptr_d   = wr_ptr_q + 1'b1;
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CW'(push) - CW'(pop);
      unique case (state_q)
        IDLE: if (EN) state_d = RUN;
        RUN: begin
          if (push && fault) state_d = HALT;
          else if (!EN)      state_d = IDLE;
        end
        HALT:    state_d = HALT;
        default: state_d = IDLE;
      endcase
    end
  end

  // Control registers with asynchronous reset
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      fetch_pc_q <= {RESET_PC[31:2], 2'b00};
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // FIFO storage; contents are only observable through the occupancy gate
  always_ff @(posedge CLK) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= wr_instr;
      pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
      fault_mem_q[wr_ptr_q] <= fault;
    end
  end

  // Head outputs, forced to zero while empty
  always_comb begin
    IMEM_A      = fetch_pc_q;
    COUNT       = count_q;
    INSTR_VALID = head_valid;
    INSTR       = head_valid ? instr_mem_q[rd_ptr_q] : '0;
    INSTR_PC    = head_valid ? pc_mem_q[rd_ptr_q]    : '0;
    INSTR_FAULT = head_valid ? fault_mem_q[rd_ptr_q] : 1'b0;
  end

endmodule

// File: tb/tb_imem_prefetch_ctrl.sv
// Bench for imem_prefetch_ctrl: ROM model, in-order PC scoreboard, scenario tasks.
module tb_imem_prefetch_ctrl;

  logic        clk = 1'b0;
  logic        rst, en, redirect, ready;
  logic [31:0] redirect_pc, imem_a, imem_rd, instr, instr_pc;
  logic        instr_valid, instr_fault;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;
  logic [31:0] sb [$];

  always #5 clk = ~clk;

  imem_prefetch_ctrl #(.DEPTH(4), .RESET_PC(32'h0), .MEM_WORDS(10001)) dut (
    .CLK(clk), .RST(rst), .EN(en), .IMEM_A(imem_a), .IMEM_RD(imem_rd),
    .REDIRECT(redirect), .REDIRECT_PC(redirect_pc), .INSTR_VALID(instr_valid),
    .INSTR_READY(ready), .INSTR(instr), .INSTR_PC(instr_pc),
    .INSTR_FAULT(instr_fault), .COUNT(count)
  );

  function automatic logic [31:0] rom(input logic [31:0] a);
    logic [31:0] w;
    w = {2'b00, a[31:2]};
    if (w == 32'd0)      return 32'h0050_0113;
    else if (w == 32'd1) return 32'h00C0_0193;
    else                 return (w * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  always_comb imem_rd = rom(imem_a);

  // Scoreboard: every accepted instruction must match the next expected PC
  always @(negedge clk) begin
    logic [31:0] epc, ei;
    logic        ef;
    if (!rst && !redirect && instr_valid && ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_pop got pc=%h expected none", instr_pc);
      end else begin
        epc = sb.pop_front();
        ef  = ((epc >> 2) >= 32'd10001);
        ei  = ef ? 32'h0000_0013 : rom(epc);
        if (instr_pc !== epc) begin
          bad++; $display("FAIL sb_pc got=%h exp=%h", instr_pc, epc);
        end
        total++;
        if (instr !== ei) begin
          bad++; $display("FAIL sb_instr pc=%h got=%h exp=%h", epc, instr, ei);
        end
        total++;
        if (instr_fault !== ef) begin
          bad++; $display("FAIL sb_fault pc=%h got=%b exp=%b", epc, instr_fault, ef);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic start_redirect(input logic [31:0] tgt, input int n);
    redirect    = 1'b1;
    redirect_pc = tgt;
    sb.delete();
    for (int i = 0; i < n; i++) sb.push_back({tgt[31:2], 2'b00} + 32'(4 * i));
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    @(negedge clk);
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", instr_valid); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", count); end
    total++; if (imem_a !== 32'h0) begin bad++; $display("FAIL rst_imem_a got=%h exp=0", imem_a); end
    total++; if (instr !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h exp=0", instr); end
    total++; if (instr_pc !== 32'h0) begin bad++; $display("FAIL rst_instr_pc got=%h exp=0", instr_pc); end
    total++; if (instr_fault !== 1'b0) begin bad++; $display("FAIL rst_fault got=%b exp=0", instr_fault); end
    step(); rst = 1'b0;
  endtask

  task automatic test_first_fetch();
    logic [31:0] exp_a;
    sb.delete();
    for (int i = 0; i < 64; i++) sb.push_back(32'(4 * i));
    en = 1'b1; ready = 1'b1;
    @(negedge clk);
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL ff_idle_valid got=%b exp=0", instr_valid); end
    step(); @(negedge clk);
    total++; if (imem_a !== 32'h0) begin bad++; $display("FAIL ff_run_imem_a got=%h exp=0", imem_a); end
    step(); @(negedge clk);
    total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL ff_first_valid got=%b exp=1", instr_valid); end
    total++; if (instr !== 32'h0050_0113) begin bad++; $display("FAIL ff_first_instr got=%h exp=00500113", instr); end
    total++; if (instr_pc !== 32'h0) begin bad++; $display("FAIL ff_first_pc got=%h exp=0", instr_pc); end
    step(); @(negedge clk);
    total++; if (instr !== 32'h00C0_0193) begin bad++; $display("FAIL ff_second_instr got=%h exp=00c00193", instr); end
    total++; if (instr_pc !== 32'h4) begin bad++; $display("FAIL ff_second_pc got=%h exp=4", instr_pc); end
    exp_a = 32'h8;
    for (int i = 0; i < 6; i++) begin
      total++; if (imem_a !== exp_a) begin bad++; $display("FAIL ff_imem_step got=%h exp=%h", imem_a, exp_a); end
      step(); @(negedge clk); exp_a += 32'd4;
    end
  endtask

  task automatic test_backpressure();
    int n;
    ready = 1'b0;
    start_redirect(32'h0, 64);
    step(); redirect = 1'b0;
    n = 0; @(negedge clk);
    while (count !== 3'd4 && n < 10) begin step(); @(negedge clk); n++; end
    total++; if (count !== 3'd4) begin bad++; $display("FAIL bp_fill got=%0d exp=4", count); end
    for (int i = 0; i < 3; i++) begin
      total++; if (count !== 3'd4) begin bad++; $display("FAIL bp_hold_count got=%0d exp=4", count); end
      total++; if (imem_a !== 32'h10) begin bad++; $display("FAIL bp_hold_imem_a got=%h exp=10", imem_a); end
      step(); @(negedge clk);
    end
    step(); ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++; if (count !== 3'd4) begin bad++; $display("FAIL full_pop_count got=%0d exp=4", count); end
      total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL full_pop_valid got=%b exp=1", instr_valid); end
      step();
    end
  endtask

  task automatic test_redirect();
    ready = 1'b0;
    start_redirect(32'h0, 8);
    step(); redirect = 1'b0;
    step(); step(); step();
    ready = 1'b1;
    start_redirect(32'h0000_004E, 40);
    @(negedge clk);
    total++; if (count !== 3'd3) begin bad++; $display("FAIL rd_pre_count got=%0d exp=3", count); end
    step(); redirect = 1'b0; @(negedge clk);
    total++; if (count !== 3'd0) begin bad++; $display("FAIL rd_flush_count got=%0d exp=0", count); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rd_flush_valid got=%b exp=0", instr_valid); end
    total++; if (imem_a !== 32'h4C) begin bad++; $display("FAIL rd_align_imem_a got=%h exp=4c", imem_a); end
    step(); @(negedge clk);
    total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL rd_target_valid got=%b exp=1", instr_valid); end
    total++; if (instr_pc !== 32'h4C) begin bad++; $display("FAIL rd_target_pc got=%h exp=4c", instr_pc); end
    step(); start_redirect(32'h100, 0);
    step(); start_redirect(32'h200, 40);
    step(); redirect = 1'b0; @(negedge clk);
    total++; if (imem_a !== 32'h200) begin bad++; $display("FAIL b2b_imem_a got=%h exp=200", imem_a); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL b2b_valid got=%b exp=0", instr_valid); end
    step(); @(negedge clk);
    total++; if (instr_pc !== 32'h200) begin bad++; $display("FAIL b2b_pc got=%h exp=200", instr_pc); end
  endtask

  task automatic test_fault();
    int n;
    ready = 1'b0;
    start_redirect(32'h0000_9C40, 2);
    step(); redirect = 1'b0;
    for (int i = 0; i < 5; i++) step();
    en = 1'b0; step(); en = 1'b1; step(); step();
    @(negedge clk);
    total++; if (count !== 3'd2) begin bad++; $display("FAIL halt_count got=%0d exp=2", count); end
    total++; if (imem_a !== 32'h9C48) begin bad++; $display("FAIL halt_imem_a got=%h exp=9c48", imem_a); end
    step(); ready = 1'b1;
    n = 0; @(negedge clk);
    while (count !== 3'd0 && n < 10) begin step(); @(negedge clk); n++; end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL halt_drain got=%0d exp=0", count); end
    for (int i = 0; i < 3; i++) begin step(); @(negedge clk); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL halt_no_push got=%b exp=0", instr_valid); end
    total++; if (imem_a !== 32'h9C48) begin bad++; $display("FAIL halt_imem_stay got=%h exp=9c48", imem_a); end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL halt_sb_left got=%0d exp=0", sb.size()); end
  endtask

  task automatic test_en_hold();
    int n;
    ready = 1'b0; en = 1'b1;
    start_redirect(32'h300, 40);
    step(); redirect = 1'b0;
    step(); step();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (count !== 3'd2) begin bad++; $display("FAIL en_hold_count got=%0d exp=2", count); end
      total++; if (imem_a !== 32'h308) begin bad++; $display("FAIL en_hold_imem_a got=%h exp=308", imem_a); end
      step();
    end
    ready = 1'b1;
    step(); step(); step(); @(negedge clk);
    total++; if (count !== 3'd0) begin bad++; $display("FAIL en_pop_drain got=%0d exp=0", count); end
    step(); en = 1'b1;
    n = 0; @(negedge clk);
    while (instr_valid !== 1'b1 && n < 6) begin step(); @(negedge clk); n++; end
    total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL en_resume got=%b exp=1", instr_valid); end
  endtask

  task automatic test_reset_mid();
    ready = 1'b0; en = 1'b1;
    start_redirect(32'h0, 40);
    step(); redirect = 1'b0;
    step(); step(); @(negedge clk);
    total++; if (count !== 3'd2) begin bad++; $display("FAIL mid_pre_count got=%0d exp=2", count); end
    #2; rst = 1'b1; sb.delete(); #1;
    total++; if (count !== 3'd0) begin bad++; $display("FAIL mid_count got=%0d exp=0", count); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b exp=0", instr_valid); end
    total++; if (imem_a !== 32'h0) begin bad++; $display("FAIL mid_imem_a got=%h exp=0", imem_a); end
    total++; if (instr_pc !== 32'h0) begin bad++; $display("FAIL mid_pc got=%h exp=0", instr_pc); end
    total++; if (instr !== 32'h0) begin bad++; $display("FAIL mid_instr got=%h exp=0", instr); end
    step(); rst = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_backpressure();
    test_redirect();
    test_fault();
    test_en_hold();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
